dds_top: RTL and testbench
==========================

// Module: dds_top
// PURPOSE
//  Single-clock DDS waveform generator driving an 8-bit parallel DAC. A 32-bit phase
//  accumulator addresses a waveform generator (sine/square/triangle/sawtooth). An
//  active-low push key cycles the waveform.
//  Top of the DDS design; no PLL, so the system clock is iclk directly.
// PARAMETERS
//  FTW          32'h0020_0000  phase increment per clock (default = 1 period / 2048 clk)
//  DEBOUNCE_CYC 4              consecutive synced-low cycles that qualify a key press
// PORTS
//  iclk        in   1  system clock (nominal 84 ns period); the only clock
//  irstn       in   1  reset, asynchronous, active-low
//  ikey_sel_n  in   1  waveform-select key, active-low, asynchronous to iclk
//  owdac_num   out  8  DAC code, offset binary (0 = min, 255 = max), registered
// BEHAVIOUR
//  Reset: one clock (iclk); reset is asynchronous and active-low (irstn).
//   - Internal reset rst_n: asserts async with irstn, deasserts through a 2-FF sync
//     (low for 2 iclk edges after irstn rises).
//   - While rst_n low: phase=0, sel=0 (sine), key sync FFs=1, debounce cnt=0, armed=1,
//     owdac_num=8'd0.
//  Phase: phase <= phase + FTW every cycle, mod 2^32 wrap, no saturation.
//   Address a = phase[31:24].
//  Key path:
//   - ikey_sel_n through 2-FF synchronizer -> ks.
//   - ks==0: cnt increments, saturating at DEBOUNCE_CYC. ks==1: cnt=0, armed=1.
//   - Press event: cnt reaches DEBOUNCE_CYC while armed; exactly one event, armed
//     clears. Further events only after ks returns to 1 (any length).
//   - Low pulses shorter than DEBOUNCE_CYC synced cycles: ignored.
//   - Event: sel <= sel+1 mod 4 (0 sine, 1 square, 2 triangle, 3 sawtooth, 3 wraps to 0).
//     Phase is NOT reset on a waveform change.
//  Waveform (combinational from a and sel, then registered into owdac_num):
//   - sine:     round(127.5 + 127.5*sin(2*pi*a/256)), clipped 0..255. a=0 ->128,
//               a=64 ->255, a=192 ->0. Use a 64-entry quarter-wave ROM + symmetry
//               (mirror on a[6], invert on a[7]).
//   - square:   a[7]==0 ? 255 : 0
//   - triangle: a[7]==0 ? {a[6:0],1'b0} : ~{a[6:0],1'b0}
//   - sawtooth: a
//  Latency: owdac_num at edge n reflects the phase and sel held before edge n
//   (1 register stage).
//  A sel change shows on owdac_num the cycle after sel updates.
//  Mid-operation reset: all state returns to reset values immediately (async).
//  Waveform restarts as sine from phase 0.
// TESTING
//  1 Reset: irstn=0 25 ns, then 1 -> owdac_num=0 during reset. 1st value after
//    rst_n release=128 (sine, a=0). Phase advances FTW/clk.
//  2 Free run, no key, FTW default -> sine period exactly 2048 clk.
//    Max 255 at a=64, min 0 at a=192.
//  3 Key low 10 clk every 2048 clk -> exactly one sel advance per pulse.
//    Order sine->square->triangle->sawtooth->sine.
//  4 Square/triangle/saw checks: a=0x7F -> 255/254/127; a=0x80 -> 0/255/128.
//  5 Glitch: key low 2 clk -> no sel change. Key held low 5000 clk -> one advance only.
//  6 Assert irstn mid-sawtooth -> owdac_num=0 async. Restarts at sine, phase 0.

Source files
------------

// File: rtl/dds_top.sv
// dds_top: single-clock DDS waveform generator for an 8-bit offset-binary DAC.
// A 32-bit phase accumulator addresses a sine/square/triangle/sawtooth generator.
// An active-low key, synchronised and debounced, cycles through the waveforms.
module dds_top #(
  parameter logic [31:0] FTW          = 32'h0020_0000,
  parameter int          DEBOUNCE_CYC = 4
) (
  input  logic       iclk,
  input  logic       irstn,
  input  logic       ikey_sel_n,
  output logic [7:0] owdac_num
);

  localparam int                CNT_W   = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(DEBOUNCE_CYC);

  // First quadrant of round(127.5 + 127.5*sin(2*pi*k/256)), k = 0..63.
  // The peak at k = 64 is not stored; it is substituted directly below.
  localparam logic [7:0] SINE_Q [64] = '{
    8'd128, 8'd131, 8'd134, 8'd137, 8'd140, 8'd143, 8'd146, 8'd149,
    8'd152, 8'd155, 8'd158, 8'd162, 8'd165, 8'd167, 8'd170, 8'd173,
    8'd176, 8'd179, 8'd182, 8'd185, 8'd188, 8'd190, 8'd193, 8'd196,
    8'd198, 8'd201, 8'd203, 8'd206, 8'd208, 8'd211, 8'd213, 8'd215,
    8'd218, 8'd220, 8'd222, 8'd224, 8'd226, 8'd228, 8'd230, 8'd232,
    8'd234, 8'd235, 8'd237, 8'd238, 8'd240, 8'd241, 8'd243, 8'd244,
    8'd245, 8'd246, 8'd248, 8'd249, 8'd250, 8'd250, 8'd251, 8'd252,
    8'd253, 8'd253, 8'd254, 8'd254, 8'd254, 8'd255, 8'd255, 8'd255
  };

  logic [1:0]       r_rst_sync;
  logic             w_rst_n;
  logic [31:0]      r_phase;
  logic             r_ks1;
  logic             r_ks2;
  logic [CNT_W-1:0] r_cnt;
  logic             r_armed;
  logic [1:0]       r_sel;
  logic             w_press;
  logic [7:0]       w_addr;
  logic [5:0]       w_q_idx;
  logic [7:0]       w_half;
  logic [7:0]       w_sine;
  logic [7:0]       w_tri;
  logic [7:0]       w_wave;

  // Internal reset: asserts with irstn, releases two clocks after irstn rises.
  always_ff @(posedge iclk or negedge irstn) begin
    if (!irstn) r_rst_sync <= 2'b00;
    else        r_rst_sync <= {r_rst_sync[0], 1'b1};
  end

  assign w_rst_n = r_rst_sync[1];

  // Phase accumulator, free-running modulo 2^32.
  always_ff @(posedge iclk or negedge w_rst_n) begin
    if (!w_rst_n) r_phase <= 32'd0;
    else          r_phase <= r_phase + FTW;
  end

  // Two-stage synchroniser for the asynchronous key; idles high.
  always_ff @(posedge iclk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_ks1 <= 1'b1;
      r_ks2 <= 1'b1;
    end else begin
      r_ks1 <= ikey_sel_n;
      r_ks2 <= r_ks1;
    end
  end

  // A press fires on the clock where the low run reaches DEBOUNCE_CYC samples.
  assign w_press = !r_ks2 && r_armed && (r_cnt == CNT_MAX - 1'b1);

  // Debounce counter; armed re-enables only once the key is seen released.
  always_ff @(posedge iclk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_cnt   <= '0;
      r_armed <= 1'b1;
    end else if (r_ks2) begin
      r_cnt   <= '0;
      r_armed <= 1'b1;
    end else begin
      if (r_cnt != CNT_MAX) r_cnt <= r_cnt + 1'b1;
      if (w_press)          r_armed <= 1'b0;
    end
  end

  // Waveform select: sine -> square -> triangle -> sawtooth -> sine.
  always_ff @(posedge iclk or negedge w_rst_n) begin
    if (!w_rst_n)     r_sel <= 2'd0;
    else if (w_press) r_sel <= r_sel + 2'd1;
  end

  assign w_addr = r_phase[31:24];

  // Waveform lookup; sine mirrors on a[6] (index 64-a) and inverts on a[7].
  always_comb begin
    w_q_idx = w_addr[6] ? (6'd0 - w_addr[5:0]) : w_addr[5:0];
    w_half  = (w_addr[6] && (w_addr[5:0] == 6'd0)) ? 8'd255 : SINE_Q[w_q_idx];
    w_sine  = w_addr[7] ? ~w_half : w_half;
    w_tri   = w_addr[7] ? ~{w_addr[6:0], 1'b0} : {w_addr[6:0], 1'b0};
    w_wave  = w_sine;
    case (r_sel)
      2'd0:    w_wave = w_sine;
      2'd1:    w_wave = w_addr[7] ? 8'd0 : 8'd255;
      2'd2:    w_wave = w_tri;
      default: w_wave = w_addr;
    endcase
  end

  // Registered DAC output.
  always_ff @(posedge iclk or negedge w_rst_n) begin
    if (!w_rst_n) owdac_num <= 8'd0;
    else          owdac_num <= w_wave;
  end

endmodule

// File: tb/tb_dds_top.sv
// tb_dds_top: scoreboard bench for dds_top. A reference model derives each
// expected DAC code from phase/selection arithmetic and the key's low-run
// lengths; a monitor compares one popped expectation per clock.
module tb_dds_top;

  localparam logic [31:0] FTW          = 32'h0020_0000;
  localparam int          DEBOUNCE_CYC = 4;

  logic       iclk;
  logic       irstn;
  logic       ikey_sel_n;
  logic [7:0] owdac_num;

  dds_top #(.FTW(FTW), .DEBOUNCE_CYC(DEBOUNCE_CYC)) dut (
    .iclk       (iclk),
    .irstn      (irstn),
    .ikey_sel_n (ikey_sel_n),
    .owdac_num  (owdac_num)
  );

  initial iclk = 1'b0;
  always #42 iclk = ~iclk;

  typedef struct {
    int a;
    int sel;
    int exp;
  } exp_t;

  exp_t        sb_q[$];
  int          n_checks = 0;
  int          n_pass   = 0;

  // reference model state
  logic [31:0] m_phase;
  int          m_sel;
  int          m_run;
  int          m_edges;
  bit          m_hist[$];

  task automatic check(input string name, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
  endtask

  // Sine from the formula for the positive half; the negative half is the
  // exact 255-complement of the positive half.
  function automatic int sine_ref(input int a);
    real r;
    int  v;
    if (a >= 128) return 255 - sine_ref(a - 128);
    r = 127.5 + 127.5 * $sin(2.0 * 3.14159265358979 * a / 256.0);
    v = $rtoi($floor(r + 0.5));
    if (v > 255) v = 255;
    if (v < 0)   v = 0;
    return v;
  endfunction

  function automatic int wave_ref(input int a, input int sel);
    case (sel)
      0:       return sine_ref(a);
      1:       return (a < 128) ? 255 : 0;
      2:       return (a < 128) ? 2 * a : 255 - 2 * (a - 128);
      default: return a;
    endcase
  endfunction

  // Fixed reference points; -1 where none is defined.
  function automatic int spot(input int sel, input int a);
    if (sel == 0 && a == 0)    return 128;
    if (sel == 0 && a == 64)   return 255;
    if (sel == 0 && a == 192)  return 0;
    if (sel == 1 && a == 127)  return 255;
    if (sel == 1 && a == 128)  return 0;
    if (sel == 2 && a == 127)  return 254;
    if (sel == 2 && a == 128)  return 255;
    if (sel == 3 && a == 127)  return 127;
    if (sel == 3 && a == 128)  return 128;
    return -1;
  endfunction

  task automatic model_reset();
    m_phase = 32'd0;
    m_sel   = 0;
    m_run   = 0;
    m_edges = 0;
    m_hist.delete();
    m_hist.push_back(1'b1);
    m_hist.push_back(1'b1);
  endtask

  // Reference model: reset is released on the third edge after irstn rises;
  // the key is seen two active clocks late; a press is a low run of exactly
  // DEBOUNCE_CYC samples.
  always @(posedge iclk) begin
    bit   ks;
    exp_t e;
    if (!irstn) begin
      model_reset();
    end else begin
      m_edges++;
      if (m_edges > 2) begin
        e.a   = int'(m_phase[31:24]);
        e.sel = m_sel;
        e.exp = wave_ref(e.a, m_sel);
        sb_q.push_back(e);
        m_phase = m_phase + FTW;
        ks = m_hist.pop_front();
        m_hist.push_back(ikey_sel_n);
        if (ks) m_run = 0;
        else    m_run++;
        if (m_run == DEBOUNCE_CYC) m_sel = (m_sel + 1) % 4;
      end
    end
  end

  // Monitor: one output per active clock, compared on the falling edge.
  always @(negedge iclk) begin
    exp_t e;
    int   s;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check($sformatf("dac a=%0d sel=%0d", e.a, e.sel), int'(owdac_num), e.exp);
      s = spot(e.sel, e.a);
      if (s >= 0) check($sformatf("spot a=%0d sel=%0d", e.a, e.sel), int'(owdac_num), s);
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge iclk);
  endtask

  task automatic press(input int low_len);
    ikey_sel_n = 1'b0;
    cycles(low_len);
    ikey_sel_n = 1'b1;
  endtask

  initial begin
    model_reset();
    ikey_sel_n = 1'b1;
    irstn      = 1'b0;
    #1;
    check("reset dac", int'(owdac_num), 0);
    #20;
    check("reset dac late", int'(owdac_num), 0);
    #4 irstn = 1'b1;
    @(negedge iclk);
    check("dac while sync reset", int'(owdac_num), 0);

    // free-running sine, two full periods
    cycles(2 * 2048);

    // one advance per 10-cycle press: square, triangle, sawtooth, sine
    for (int i = 0; i < 4; i++) begin
      press(10);
      cycles(2048);
    end

    // short glitches are ignored
    for (int i = 0; i < 6; i++) begin
      press(2);
      cycles(20);
    end

    // long hold gives a single advance
    press(5000);
    cycles(300);

    // randomized key activity around the debounce threshold
    for (int i = 0; i < 30; i++) begin
      press($urandom_range(1, 8));
      cycles($urandom_range(1, 40));
    end
    cycles(200);

    // get to sawtooth, then reset in the middle of it
    for (int i = 0; i < 4 && m_sel != 3; i++) begin
      press(10);
      cycles(20);
    end
    cycles(400);
    check("sel before mid reset", m_sel, 3);
    #10 irstn = 1'b0;
    #1;
    check("mid reset dac async", int'(owdac_num), 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge iclk);
      check("mid reset dac held", int'(owdac_num), 0);
    end
    irstn = 1'b1;
    cycles(2100);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
